// File: rtl/spi_cmd_parser_if.sv
// spi_cmd_parser_if
//   Byte-level link between the upstream SPI slave front end and the command parser.
//   rxd_data : byte received in the frame just closed (valid while rxd_flag=1)
//   rxd_flag : one-cycle pulse at the end of each CS_N frame
//   txd_flag : one-cycle pulse marking completion of a transmit frame
//   txd_data : byte the SPI slave shifts out in the next frame
//   master   : SPI slave front end side
//   slave    : command parser side
interface spi_cmd_parser_if;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  logic       txd_flag;
  logic [7:0] txd_data;

  modport master (
    output rxd_data,
    output rxd_flag,
    output txd_flag,
    input  txd_data
  );

  modport slave (
    input  rxd_data,
    input  rxd_flag,
    input  txd_flag,
    output txd_data
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser
//   Decodes one-byte SPI frames into register reads/writes. A command byte
//   (bit7=1 write, bit7=0 read, bits[6:0] address) is followed by a data frame
//   (write) or a dummy frame during which the read value is shifted out.
//   An inter-frame timeout returns the FSM to IDLE with an error strobe.
// Ports
//   sys_clk, rst_n   : clock, asynchronous active-low reset
//   spi              : byte link to the SPI slave (rxd_data/rxd_flag/txd_flag in, txd_data out)
//   status_in        : live acquisition status, readable at 0x05
//   ctrl_run, trig_edge, single_shot : CTRL bits 0..2
//   trig_level       : trigger threshold
//   timebase_div     : sample-clock divider, never 0
//   ch_sel           : channel select
//   arm_pulse        : one-cycle strobe on a write to 0x07
//   cmd_err          : one-cycle strobe on illegal access or timeout
//   busy             : high whenever the FSM is not IDLE
module spi_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  DEV_ID         = 8'hA5
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  spi_cmd_parser_if.slave        spi,
  input  logic [7:0]             status_in,
  output logic                   ctrl_run,
  output logic                   trig_edge,
  output logic                   single_shot,
  output logic [7:0]             trig_level,
  output logic [7:0]             timebase_div,
  output logic [1:0]             ch_sel,
  output logic                   arm_pulse,
  output logic                   cmd_err,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    READ_PEND = 2'd2
  } state_t;

  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  txd_q, txd_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  trig_q, trig_d;
  logic [7:0]  tdiv_q, tdiv_d;
  logic [1:0]  ch_q, ch_d;
  logic [7:0]  scratch_q, scratch_d;
  logic        arm_q, arm_d;
  logic        err_q, err_d;

  logic [7:0]  rd_val;
  logic        rd_bad;
  logic        timeout;

  // Read mux is addressed by the incoming command byte so STATUS is
  // captured at the moment the read command is decoded.
  always_comb begin
    rd_val = '0;
    rd_bad = 1'b0;
    case (spi.rxd_data[6:0])
      7'h00:   rd_val = DEV_ID;
      7'h01:   rd_val = {5'b0, ctrl_q};
      7'h02:   rd_val = trig_q;
      7'h03:   rd_val = tdiv_q;
      7'h04:   rd_val = {6'b0, ch_q};
      7'h05:   rd_val = status_in;
      7'h06:   rd_val = scratch_q;
      7'h07:   rd_val = '0;
      default: rd_bad = 1'b1;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 20'd1;
    addr_d    = addr_q;
    txd_d     = txd_q;
    ctrl_d    = ctrl_q;
    trig_d    = trig_q;
    tdiv_d    = tdiv_q;
    ch_d      = ch_q;
    scratch_d = scratch_q;
    arm_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Counter held at zero here so it starts from 0 on entry to a busy state.
        cnt_d = '0;
        if (spi.rxd_flag) begin
          addr_d = spi.rxd_data[6:0];
          if (spi.rxd_data[7]) begin
            state_d = WAIT_DATA;
          end else begin
            txd_d   = rd_val;
            err_d   = rd_bad;
            state_d = READ_PEND;
          end
        end
      end

      WAIT_DATA: begin
        // A received frame takes priority over a simultaneous timeout.
        if (spi.rxd_flag) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (addr_q)
            7'h01:   ctrl_d    = spi.rxd_data[2:0];
            7'h02:   trig_d    = spi.rxd_data;
            7'h03:   tdiv_d    = (spi.rxd_data == 8'h00) ? 8'h01 : spi.rxd_data;
            7'h04:   ch_d      = spi.rxd_data[1:0];
            7'h06:   scratch_d = spi.rxd_data;
            7'h07:   arm_d     = 1'b1;
            default: err_d     = 1'b1;
          endcase
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          txd_d   = '0;
          err_d   = 1'b1;
        end
      end

      READ_PEND: begin
        // rxd_flag and txd_flag together close a single frame.
        if (spi.rxd_flag || spi.txd_flag) begin
          state_d = IDLE;
          cnt_d   = '0;
          txd_d   = '0;
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          txd_d   = '0;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      txd_q     <= '0;
      ctrl_q    <= '0;
      trig_q    <= 8'h80;
      tdiv_q    <= 8'h01;
      ch_q      <= '0;
      scratch_q <= '0;
      arm_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      txd_q     <= txd_d;
      ctrl_q    <= ctrl_d;
      trig_q    <= trig_d;
      tdiv_q    <= tdiv_d;
      ch_q      <= ch_d;
      scratch_q <= scratch_d;
      arm_q     <= arm_d;
      err_q     <= err_d;
    end
  end

  assign spi.txd_data  = txd_q;
  assign ctrl_run      = ctrl_q[0];
  assign trig_edge     = ctrl_q[1];
  assign single_shot   = ctrl_q[2];
  assign trig_level    = trig_q;
  assign timebase_div  = tdiv_q;
  assign ch_sel        = ch_q;
  assign arm_pulse     = arm_q;
  assign cmd_err       = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_parser.sv
module tb_spi_cmd_parser;
  localparam int unsigned TO = 16;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] status_in;
  logic       ctrl_run, trig_edge, single_shot;
  logic [7:0] trig_level, timebase_div;
  logic [1:0] ch_sel;
  logic       arm_pulse, cmd_err, busy;

  spi_cmd_parser_if bus ();

  spi_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .DEV_ID        (8'hA5)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .spi         (bus),
    .status_in   (status_in),
    .ctrl_run    (ctrl_run),
    .trig_edge   (trig_edge),
    .single_shot (single_shot),
    .trig_level  (trig_level),
    .timebase_div(timebase_div),
    .ch_sel      (ch_sel),
    .arm_pulse   (arm_pulse),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  txd;
    logic [2:0]  ctrl;
    logic [7:0]  trig;
    logic [7:0]  tdiv;
    logic [1:0]  ch;
    logic        arm;
    logic        err;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        frame_seen = 1'b0;

  // Transaction-level reference: register contents plus which frame the
  // protocol expects next (0 command, 1 write data, 2 read dummy).
  logic [7:0]  m_txd, m_trig, m_tdiv, m_scratch;
  logic [2:0]  m_ctrl;
  logic [1:0]  m_ch;
  logic [6:0]  m_addr;
  int          m_phase;
  int unsigned m_entry;

  function automatic void model_reset();
    m_txd = 8'h00; m_trig = 8'h80; m_tdiv = 8'h01; m_scratch = 8'h00;
    m_ctrl = 3'b0; m_ch = 2'b0; m_addr = 7'h0; m_phase = 0; m_entry = 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a, input logic [7:0] st);
    case (a)
      7'd0:    return 8'hA5;
      7'd1:    return {5'b0, m_ctrl};
      7'd2:    return m_trig;
      7'd3:    return m_tdiv;
      7'd4:    return {6'b0, m_ch};
      7'd5:    return st;
      7'd6:    return m_scratch;
      default: return 8'h00;
    endcase
  endfunction

  function automatic exp_t snapshot(input int unsigned c, input logic arm, input logic err,
                                    input string tag);
    exp_t e;
    e.cyc = c; e.txd = m_txd; e.ctrl = m_ctrl; e.trig = m_trig; e.tdiv = m_tdiv;
    e.ch = m_ch; e.arm = arm; e.err = err; e.busy = (m_phase != 0); e.tag = tag;
    return e;
  endfunction

  // Called on a negedge; drives one frame for one cycle and queues the
  // outputs expected right after the sampling edge.
  task automatic send_frame(input logic [7:0] b, input logic rx, input logic tx, input string tag);
    logic arm, err;
    arm = 1'b0; err = 1'b0;
    status_in    = 8'($urandom);
    bus.rxd_data = b;
    bus.rxd_flag = rx;
    bus.txd_flag = tx;
    case (m_phase)
      0: if (rx) begin
        m_addr  = b[6:0];
        m_entry = cyc + 1;
        if (b[7]) begin
          m_phase = 1;
        end else begin
          m_txd   = model_read(b[6:0], status_in);
          err     = (b[6:0] > 7'd7);
          m_phase = 2;
        end
      end
      1: if (rx) begin
        m_phase = 0;
        case (m_addr)
          7'd1:    m_ctrl = b[2:0];
          7'd2:    m_trig = b;
          7'd3:    m_tdiv = (b == 8'h00) ? 8'h01 : b;
          7'd4:    m_ch = b[1:0];
          7'd6:    m_scratch = b;
          7'd7:    arm = 1'b1;
          default: err = 1'b1;
        endcase
      end
      default: if (rx || tx) begin
        m_txd   = 8'h00;
        m_phase = 0;
      end
    endcase
    sb.push_back(snapshot(cyc + 1, arm, err, tag));
    @(negedge sys_clk);
    bus.rxd_flag = 1'b0;
    bus.txd_flag = 1'b0;
    bus.rxd_data = 8'($urandom);
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic idle_timeout(input string tag);
    if (m_phase != 0) begin
      m_txd   = 8'h00;
      m_phase = 0;
      sb.push_back(snapshot(m_entry + TO, 1'b0, 1'b1, tag));
    end
    gap(TO + 4);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_txd"},  bus.txd_data, 8'h00);
    check_val({tag, "_ctrl"}, {5'b0, single_shot, trig_edge, ctrl_run}, 8'h00);
    check_val({tag, "_trig"}, trig_level, 8'h80);
    check_val({tag, "_tdiv"}, timebase_div, 8'h01);
    check_val({tag, "_ch"},   {6'b0, ch_sel}, 8'h00);
    check_val({tag, "_strb"}, {5'b0, arm_pulse, cmd_err, busy}, 8'h00);
  endtask

  always @(posedge sys_clk) begin
    cyc        <= cyc + 1;
    frame_seen <= bus.rxd_flag | bus.txd_flag;
  end

  // Monitor: any frame or strobe must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (rst_n && (frame_seen || cmd_err || arm_pulse)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d: got arm=%b err=%b txd=%h busy=%b, want nothing queued",
                 cyc, arm_pulse, cmd_err, bus.txd_data, busy);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc || bus.txd_data !== mon_e.txd ||
            {single_shot, trig_edge, ctrl_run} !== mon_e.ctrl || trig_level !== mon_e.trig ||
            timebase_div !== mon_e.tdiv || ch_sel !== mon_e.ch || arm_pulse !== mon_e.arm ||
            cmd_err !== mon_e.err || busy !== mon_e.busy) begin
          errors++;
          $display("FAIL %s: got cyc=%0d txd=%h ctrl=%b trig=%h tdiv=%h ch=%h arm=%b err=%b busy=%b; want cyc=%0d txd=%h ctrl=%b trig=%h tdiv=%h ch=%h arm=%b err=%b busy=%b",
                   mon_e.tag, cyc, bus.txd_data, {single_shot, trig_edge, ctrl_run}, trig_level,
                   timebase_div, ch_sel, arm_pulse, cmd_err, busy, mon_e.cyc, mon_e.txd,
                   mon_e.ctrl, mon_e.trig, mon_e.tdiv, mon_e.ch, mon_e.arm, mon_e.err, mon_e.busy);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    int unsigned kind;
    bus.rxd_data = 8'h00;
    bus.rxd_flag = 1'b0;
    bus.txd_flag = 1'b0;
    status_in    = 8'h00;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    gap(2);

    // Directed scenarios
    send_frame(8'h82, 1'b1, 1'b0, "wr_trig_cmd");  gap(2);
    send_frame(8'h3C, 1'b1, 1'b0, "wr_trig_data"); gap(1);
    send_frame(8'h00, 1'b1, 1'b0, "rd_id");        gap(1);
    send_frame(8'hFF, 1'b1, 1'b0, "rd_id_dummy");  gap(1);
    send_frame(8'h83, 1'b1, 1'b0, "wr_tdiv_cmd");  gap(1);
    send_frame(8'h00, 1'b1, 1'b0, "wr_tdiv_zero"); gap(1);
    send_frame(8'h81, 1'b1, 1'b0, "wr_ctrl_cmd");  gap(1);
    send_frame(8'h05, 1'b1, 1'b0, "wr_ctrl_data"); gap(1);
    send_frame(8'h87, 1'b1, 1'b0, "wr_arm_cmd");   gap(1);
    send_frame(8'h11, 1'b1, 1'b0, "wr_arm_data");  gap(2);
    send_frame(8'h85, 1'b1, 1'b0, "wr_status_cmd"); gap(1);
    send_frame(8'h12, 1'b1, 1'b0, "wr_status_err"); gap(1);
    send_frame(8'h40, 1'b1, 1'b0, "rd_bad_addr");   gap(1);
    send_frame(8'h00, 1'b0, 1'b1, "rd_bad_dummy");  gap(1);
    send_frame(8'h86, 1'b1, 1'b0, "wr_scr_cmd");    gap(1);
    send_frame(8'h5A, 1'b1, 1'b1, "wr_scr_data");   gap(1);
    send_frame(8'h82, 1'b1, 1'b0, "to_cmd");
    idle_timeout("timeout");
    send_frame(8'h06, 1'b1, 1'b0, "rd_scr_after_to"); gap(1);
    send_frame(8'h00, 1'b1, 1'b1, "rd_scr_dummy");    gap(1);

    // Reset in the middle of a write transaction
    send_frame(8'h82, 1'b1, 1'b0, "abort_cmd");
    gap(1);
    rst_n = 1'b0;
    model_reset();
    gap(2);
    check_reset_state("midreset");
    rst_n = 1'b1;
    gap(1);
    send_frame(8'h3C, 1'b1, 1'b0, "first_after_rst"); gap(1);
    send_frame(8'h00, 1'b0, 1'b1, "first_after_rst_dummy"); gap(1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      if (kind <= 4) begin
        send_frame({1'b1, a}, 1'b1, 1'b0, "rnd_wr_cmd");
        gap($urandom_range(0, 3));
        send_frame(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 1'b1,
                   1'($urandom_range(0, 1)), "rnd_wr_data");
      end else if (kind <= 7) begin
        send_frame({1'b0, a}, 1'b1, 1'b0, "rnd_rd_cmd");
        gap($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0:       send_frame(8'($urandom), 1'b1, 1'b0, "rnd_rd_dummy_rx");
          1:       send_frame(8'($urandom), 1'b0, 1'b1, "rnd_rd_dummy_tx");
          default: send_frame(8'($urandom), 1'b1, 1'b1, "rnd_rd_dummy_both");
        endcase
      end else if (kind == 8) begin
        send_frame({1'($urandom_range(0, 1)), a}, 1'b1, 1'b0, "rnd_to_cmd");
        idle_timeout("rnd_timeout");
      end else begin
        send_frame(8'($urandom), 1'b0, 1'b1, "rnd_stray_tx");
      end
      gap($urandom_range(0, 3));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expectations, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
